cpu_sequencer: RTL

Instruction-cycle controller for the discrete-logic CPU datapath. It drives the load, increment and memory strobes for the DFF-based registers: P (program counter), IR, MA (memory address) and A (accumulator). It steps each instruction through fetch, optional indirect defer and execute, handles run, halt and single-step, and watches for memory time-outs. It sits between the front-panel run controls, the memory handshake and the register enables.

---
 rtl/cpu_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: fetch / optional indirect defer / execute, run-halt-step, memory time-out.
// Latency: strobes are combinational from the registered state; the target register captures on the accepting edge.
// Backpressure: memory states hold while mem_ready=0, up to WAIT_LIMIT extra cycles, then FAULT.
module cpu_sequencer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       halt_req,
    input  logic [2:0] ir_op,
    input  logic       ir_ind,
    input  logic       acc_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       sel_addr,
    output logic       load_ir,
    output logic       load_ma,
    output logic       load_a,
    output logic       load_p,
    output logic       inc_p,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);

    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] WLIM = CW'(WAIT_LIMIT);

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_DEFER  = 3'd3,
        S_EXEC   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t          cur;
    state_t          nxt;
    logic [CW-1:0]   wait_cnt;
    logic            halt_pend;
    logic            mem_state;
    logic            at_limit;
    logic            eoi;

    // EXEC is a memory state only for LDA/STA/ADD/AND (ops 0..3)
    assign mem_state = (cur == S_FETCH) || (cur == S_DEFER) || ((cur == S_EXEC) && !ir_op[2]);
    assign at_limit  = (wait_cnt == WLIM);

    assign halted = (cur == S_HALT);
    assign fault  = (cur == S_FAULT);
    assign state  = cur;

    always_comb begin
        nxt      = cur;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        sel_addr = 1'b0;
        load_ir  = 1'b0;
        load_ma  = 1'b0;
        load_a   = 1'b0;
        load_p   = 1'b0;
        inc_p    = 1'b0;
        eoi      = 1'b0;
        unique case (cur)
            S_HALT: begin
                if (start) nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    load_ir = 1'b1;
                    load_ma = 1'b1;
                    inc_p   = 1'b1;
                    nxt     = S_DECODE;
                end else if (at_limit) begin
                    nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                nxt = (ir_ind && (ir_op <= 3'd5)) ? S_DEFER : S_EXEC;
            end
            S_DEFER: begin
                mem_req  = 1'b1;
                sel_addr = 1'b1;
                if (mem_ready) begin
                    load_ma = 1'b1;
                    nxt     = S_EXEC;
                end else if (at_limit) begin
                    nxt = S_FAULT;
                end
            end
            S_EXEC: begin
                case (ir_op)
                    3'd0, 3'd2, 3'd3: begin
                        mem_req  = 1'b1;
                        sel_addr = 1'b1;
                        if (mem_ready) begin
                            load_a = 1'b1;
                            eoi    = 1'b1;
                        end else if (at_limit) begin
                            nxt = S_FAULT;
                        end
                    end
                    3'd1: begin
                        mem_req  = 1'b1;
                        mem_we   = 1'b1;
                        sel_addr = 1'b1;
                        if (mem_ready) eoi = 1'b1;
                        else if (at_limit) nxt = S_FAULT;
                    end
                    3'd4: begin
                        load_p = 1'b1;
                        eoi    = 1'b1;
                    end
                    3'd5: begin
                        load_p = acc_zero;
                        eoi    = 1'b1;
                    end
                    3'd6: eoi = 1'b1;
                    default: nxt = S_HALT;
                endcase
            end
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_HALT;
        endcase

        if (eoi) nxt = (halt_pend || halt_req) ? S_HALT : S_FETCH;

        // reset suppresses every strobe in the cycle it is asserted
        if (rst) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            sel_addr = 1'b0;
            load_ir  = 1'b0;
            load_ma  = 1'b0;
            load_a   = 1'b0;
            load_p   = 1'b0;
            inc_p    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= S_HALT;
            wait_cnt  <= '0;
            halt_pend <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready && !at_limit)
                wait_cnt <= wait_cnt + CW'(1);
            // in HALT, halt_req only latches together with start (single-step)
            if ((nxt == S_HALT) && (cur != S_HALT))
                halt_pend <= 1'b0;
            else if (halt_req && (cur != S_FAULT) && ((cur != S_HALT) || start))
                halt_pend <= 1'b1;
        end
    end

endmodule
